snitch_event_counter_unit: RTL
==============================

SNITCH_EVENT_COUNTER_UNIT -- requirements
Module: snitch_event_counter_unit

Interface
REQ-001 SHALL have parameter NrCores, default 8, number of cores with event strobes (1..32).
REQ-002 SHALL have parameter NrCounters, default 4, number of independent counters (1..8).
REQ-003 SHALL have parameter CounterWidth, default 48, counter width in bits (33..64).
REQ-004 SHALL have port clk_i  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst_ni  input  1  reset: asynchronous, active-low.
REQ-006 SHALL have port events_i  input  NrCores x core_events_t  per-core event strobes (7 bits each).
REQ-007 SHALL have port req_valid_i / req_ready_o  input / output  1 / 1  register request handshake.
REQ-008 SHALL have port req_write_i  input  1  1 = write, 0 = read.
REQ-009 SHALL have port req_addr_i  input  8  byte address, word aligned.
REQ-010 SHALL have port req_wdata_i  input  32  write data.
REQ-011 SHALL have port rsp_valid_o / rsp_ready_i  output / input  1 / 1  response handshake.
REQ-012 SHALL have port rsp_rdata_o / rsp_error_o  output  32 / 1  read data, decode error.
REQ-013 SHALL have port irq_o  output  NrCounters  per-counter overflow interrupt, level.

Function
REQ-014 SHALL map counter c at base 0x10*c: +0x0 CFG, +0x4 HART_MASK, +0x8 VALUE_LO, +0xC VALUE_HI; OVF_STATUS at 0x10*NrCounters; all other addresses give rsp_error_o=1, rdata 0, no state change.
REQ-015 CFG fields SHALL be: [0] enable, [3:1] event index (bit position in core_events_t; 7 never counts), [4] saturate(1)/wrap(0), [5] irq enable; other bits read 0.
REQ-016 events_i SHALL be registered once; the counter update SHALL occur on the following edge (strobe in cycle t visible in VALUE at cycle t+2).
REQ-017 Per cycle, an enabled counter SHALL increment by popcount of selected event bit over cores set in HART_MASK (0..NrCores).
REQ-018 If value+increment exceeds 2^CounterWidth-1: wrap mode stores the sum modulo 2^CounterWidth; saturate mode stores all ones; both set OVF_STATUS[c].
REQ-019 OVF_STATUS SHALL be sticky, write-1-to-clear; clear and simultaneous set in the same cycle SHALL leave the bit set.
REQ-020 irq_o[c] SHALL equal OVF_STATUS[c] AND CFG[c].irq_en, combinationally from registers.
REQ-021 Read of VALUE_LO SHALL return bits [31:0] and latch bits [CounterWidth-1:32] of the same counter into a per-counter shadow; read of VALUE_HI SHALL return the shadow, zero-extended.
REQ-022 Write of VALUE_LO/VALUE_HI SHALL replace the respective bits; a software write SHALL win over a same-cycle increment, which is dropped.
REQ-023 Requests SHALL be accepted when req_valid_i and req_ready_o; req_ready_o SHALL be 0 while rsp_valid_o=1 and rsp_ready_i=0 (one outstanding).
REQ-024 Response SHALL assert rsp_valid_o the cycle after acceptance, holding rdata/error stable until rsp_ready_i; read data reflects register state at the accepting edge.
REQ-025 Writes SHALL take effect at the accepting edge; writes return rdata 0.

Reset
REQ-026 On rst_ni low: all counters, CFG, HART_MASK, shadows, OVF_STATUS, event register = 0; rsp_valid_o=0, rsp_error_o=0, rsp_rdata_o=0, req_ready_o=1, irq_o=0.
REQ-027 Reset mid-transaction SHALL drop any pending response without replay.

Structure
REQ-028 Register offsets, CFG field positions and a cfg typedef SHALL live in snitch_pkg; core_events_t SHALL be reused from it.
REQ-029 One sub-module snitch_event_counter (single counter: popcount, add, wrap/saturate, overflow) SHALL be instantiated NrCounters times.

Verification
REQ-030 CFG0=0x3 (en, event 1), mask 0x1, core0 issue_fpu_seq high 10 cycles -> VALUE_LO0=10 two cycles after last strobe.
REQ-031 Mask 0xFF, event retired_instr on all 8 cores for 5 cycles -> VALUE_LO=40.
REQ-032 Wrap mode, value 2^48-2, increment 3 -> value 1, OVF_STATUS[0]=1, irq_o[0]=1 if CFG[5]; saturate mode -> value 0xFFFF_FFFF_FFFF.
REQ-033 Read LO while counting with value 0x1_FFFF_FFFF -> LO 0xFFFFFFFF, following HI read 0x1 despite carry.
REQ-034 Read 0xF4 -> rsp_error_o=1, rdata 0; rsp_ready_i held low 3 cycles -> req_ready_o=0, response stable.
REQ-035 Write OVF_STATUS=0x1 same cycle as new overflow -> bit stays 1; rst_ni low mid-response -> all outputs at reset values.

Source files
------------

// File: rtl/snitch_pkg.sv
// Shared types and register map for the Snitch event counter unit.
package snitch_pkg;

  // Per-core event strobes; field order fixes the bit index selected by CFG.
  typedef struct packed {
    logic retired_instr;      // bit 6
    logic retired_load;       // bit 5
    logic retired_i;          // bit 4
    logic retired_acc;        // bit 3
    logic issue_fpu;          // bit 2
    logic issue_fpu_seq;      // bit 1
    logic issue_core_to_fpu;  // bit 0
  } core_events_t;

  // Register offsets within one counter's 16-byte window.
  localparam logic [3:0] RegCfg      = 4'h0;
  localparam logic [3:0] RegHartMask = 4'h4;
  localparam logic [3:0] RegValueLo  = 4'h8;
  localparam logic [3:0] RegValueHi  = 4'hC;

  // CFG field positions.
  localparam int unsigned CfgEnBit  = 0;
  localparam int unsigned CfgEvtLsb = 1;
  localparam int unsigned CfgEvtMsb = 3;
  localparam int unsigned CfgSatBit = 4;
  localparam int unsigned CfgIrqBit = 5;
  localparam int unsigned CfgWidth  = 6;

  // Decoded counter configuration.
  typedef struct packed {
    logic       irq_en;
    logic       saturate;
    logic [2:0] evt_idx;
    logic       enable;
  } evt_cfg_t;

  function automatic evt_cfg_t cfg_from_word(input logic [CfgWidth-1:0] w);
    evt_cfg_t c;
    c.enable   = w[CfgEnBit];
    c.evt_idx  = w[CfgEvtMsb:CfgEvtLsb];
    c.saturate = w[CfgSatBit];
    c.irq_en   = w[CfgIrqBit];
    return c;
  endfunction

  function automatic logic [31:0] cfg_to_word(input evt_cfg_t c);
    logic [31:0] w;
    w                      = '0;
    w[CfgEnBit]            = c.enable;
    w[CfgEvtMsb:CfgEvtLsb] = c.evt_idx;
    w[CfgSatBit]           = c.saturate;
    w[CfgIrqBit]           = c.irq_en;
    return w;
  endfunction

endpackage

// File: rtl/snitch_event_counter.sv
// One event counter: masked popcount of the selected event, add, wrap or
// saturate, and an overflow pulse for the sticky status in the parent.
module snitch_event_counter
  import snitch_pkg::*;
#(
  parameter int unsigned NrCores      = 8,
  parameter int unsigned CounterWidth = 48
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  evt_cfg_t                       cfg_i,
  input  logic         [NrCores-1:0]     mask_i,
  input  core_events_t [NrCores-1:0]     events_i,
  input  logic                           wr_lo_i,
  input  logic                           wr_hi_i,
  input  logic         [31:0]            wdata_i,
  output logic         [CounterWidth-1:0] value_o,
  output logic                           ovf_o
);

  localparam int unsigned IncWidth = $clog2(NrCores + 1);
  localparam int unsigned SumWidth = CounterWidth + 1;
  localparam int unsigned HiWidth  = CounterWidth - 32;

  logic [IncWidth-1:0]     incr;
  logic [7:0]              ev_bits;
  logic [SumWidth-1:0]     sum;
  logic [CounterWidth-1:0] value_q;
  logic [CounterWidth-1:0] value_d;
  logic                    unused_irq_en;

  // irq enable is consumed by the parent, not here.
  assign unused_irq_en = cfg_i.irq_en;

  // Count masked cores whose selected event bit is set; index 7 reads a constant 0.
  always_comb begin
    incr    = '0;
    ev_bits = '0;
    for (int k = 0; k < NrCores; k++) begin
      ev_bits = {1'b0, events_i[k]};
      if (mask_i[k] && ev_bits[cfg_i.evt_idx]) begin
        incr = incr + IncWidth'(1);
      end
    end
  end

  assign sum = {1'b0, value_q} + SumWidth'(incr);

  // Software writes take priority and drop this cycle's increment.
  always_comb begin
    value_d = value_q;
    ovf_o   = 1'b0;
    if (wr_lo_i || wr_hi_i) begin
      if (wr_lo_i) value_d[31:0] = wdata_i;
      if (wr_hi_i) value_d[CounterWidth-1:32] = wdata_i[HiWidth-1:0];
    end else if (cfg_i.enable) begin
      ovf_o = sum[CounterWidth];
      if (sum[CounterWidth] && cfg_i.saturate) begin
        value_d = '1;
      end else begin
        value_d = sum[CounterWidth-1:0];
      end
    end
  end

  // Counter state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value_o = value_q;

endmodule

// File: rtl/snitch_event_counter_unit.sv
// Bank of event counters behind a single-outstanding register interface,
// with sticky overflow status and per-counter level interrupts.
module snitch_event_counter_unit
  import snitch_pkg::*;
#(
  parameter int unsigned NrCores      = 8,
  parameter int unsigned NrCounters   = 4,
  parameter int unsigned CounterWidth = 48
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  core_events_t [NrCores-1:0] events_i,
  input  logic                       req_valid_i,
  output logic                       req_ready_o,
  input  logic                       req_write_i,
  input  logic         [7:0]         req_addr_i,
  input  logic         [31:0]        req_wdata_i,
  output logic                       rsp_valid_o,
  input  logic                       rsp_ready_i,
  output logic         [31:0]        rsp_rdata_o,
  output logic                       rsp_error_o,
  output logic         [NrCounters-1:0] irq_o
);

  localparam int unsigned HiWidth     = CounterWidth - 32;
  localparam logic [7:0]  OvfAddr     = 8'(NrCounters * 16);
  localparam logic [4:0]  NrCountersW = 5'(NrCounters);

  core_events_t [NrCores-1:0]                    events_q;
  logic         [NrCounters-1:0][CounterWidth-1:0] value;
  logic         [NrCounters-1:0][31:0]           cnt_rdata;
  logic [NrCounters-1:0] ovf_q, ovf_set, ovf_clr;
  logic [NrCounters-1:0] wr_cfg, wr_mask, wr_lo, wr_hi, rd_lo;
  logic        accept, wr_fire, rd_fire;
  logic        aligned, cnt_hit, ovf_hit, dec_err;
  logic [3:0]  cnt_idx, reg_off;
  logic [31:0] rdata_mux;
  logic        rsp_valid_q, rsp_error_q;
  logic [31:0] rsp_rdata_q;

  // Handshake: stall new requests only while a response is stuck.
  assign req_ready_o = !(rsp_valid_q && !rsp_ready_i);
  assign accept      = req_valid_i && req_ready_o;
  assign wr_fire     = accept && req_write_i;
  assign rd_fire     = accept && !req_write_i;

  // Address decode.
  assign cnt_idx = req_addr_i[7:4];
  assign reg_off = req_addr_i[3:0];
  assign aligned = (req_addr_i[1:0] == 2'b00);
  assign cnt_hit = aligned && ({1'b0, cnt_idx} < NrCountersW);
  assign ovf_hit = (req_addr_i == OvfAddr);
  assign dec_err = !(cnt_hit || ovf_hit);

  // Event strobes are registered once before they reach the counters.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      events_q <= '0;
    end else begin
      events_q <= events_i;
    end
  end

  for (genvar gi = 0; gi < NrCounters; gi++) begin : g_cnt
    evt_cfg_t           cfg_q;
    logic [NrCores-1:0] mask_q;
    logic [HiWidth-1:0] shadow_q;
    logic               sel;
    logic [31:0]        rdata_c;

    assign sel         = cnt_hit && (cnt_idx == 4'(gi));
    assign wr_cfg[gi]  = wr_fire && sel && (reg_off == RegCfg);
    assign wr_mask[gi] = wr_fire && sel && (reg_off == RegHartMask);
    assign wr_lo[gi]   = wr_fire && sel && (reg_off == RegValueLo);
    assign wr_hi[gi]   = wr_fire && sel && (reg_off == RegValueHi);
    assign rd_lo[gi]   = rd_fire && sel && (reg_off == RegValueLo);
    assign ovf_clr[gi] = wr_fire && ovf_hit && req_wdata_i[gi];
    assign irq_o[gi]   = ovf_q[gi] & cfg_q.irq_en;

    // Configuration, hart mask and the high-half shadow captured on LO reads.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        cfg_q    <= '0;
        mask_q   <= '0;
        shadow_q <= '0;
      end else begin
        if (wr_cfg[gi])  cfg_q    <= cfg_from_word(req_wdata_i[CfgWidth-1:0]);
        if (wr_mask[gi]) mask_q   <= req_wdata_i[NrCores-1:0];
        if (rd_lo[gi])   shadow_q <= value[gi][CounterWidth-1:32];
      end
    end

    // Read data for this counter's window.
    always_comb begin
      rdata_c = '0;
      case (reg_off)
        RegCfg:      rdata_c = cfg_to_word(cfg_q);
        RegHartMask: rdata_c = 32'(mask_q);
        RegValueLo:  rdata_c = value[gi][31:0];
        RegValueHi:  rdata_c = 32'(shadow_q);
        default:     rdata_c = '0;
      endcase
    end

    assign cnt_rdata[gi] = rdata_c;

    snitch_event_counter #(
      .NrCores      (NrCores),
      .CounterWidth (CounterWidth)
    ) i_counter (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .cfg_i    (cfg_q),
      .mask_i   (mask_q),
      .events_i (events_q),
      .wr_lo_i  (wr_lo[gi]),
      .wr_hi_i  (wr_hi[gi]),
      .wdata_i  (req_wdata_i),
      .value_o  (value[gi]),
      .ovf_o    (ovf_set[gi])
    );
  end

  // Sticky overflow: a new overflow wins over a same-cycle clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ovf_q <= '0;
    end else begin
      ovf_q <= (ovf_q & ~ovf_clr) | ovf_set;
    end
  end

  // Select read data for the addressed register.
  always_comb begin
    rdata_mux = '0;
    if (ovf_hit) rdata_mux = 32'(ovf_q);
    for (int c = 0; c < NrCounters; c++) begin
      if (cnt_hit && (cnt_idx == 4'(c))) rdata_mux = cnt_rdata[c];
    end
  end

  // Response register: loaded on accept, held until the consumer takes it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_valid_q <= 1'b0;
      rsp_error_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else if (accept) begin
      rsp_valid_q <= 1'b1;
      rsp_error_q <= dec_err;
      rsp_rdata_q <= (req_write_i || dec_err) ? 32'h0 : rdata_mux;
    end else if (rsp_ready_i) begin
      rsp_valid_q <= 1'b0;
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_error_o = rsp_error_q;
  assign rsp_rdata_o = rsp_rdata_q;

endmodule
